// File: rtl/cordic_pkg.sv
// Shared constants for the pipelined sin/cos CORDIC: angle format, gain-compensated
// start vector and the per-stage arctangent table (2^24 angle units per turn).
package cordic_pkg;

  localparam int ANGLE_W = 24;
  localparam logic [ANGLE_W-1:0] QUARTER = 24'h400000;

  // CORDIC gain compensation 0.6072529350, held as an integer scaled by 1e10
  localparam longint CORDIC_GAIN_E10 = 64'sd6072529350;

  function automatic longint k_init(input int data_w, input int guard);
    longint fs;
    fs = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    return (fs * (64'sd1 <<< guard) * CORDIC_GAIN_E10 + 64'sd5000000000) / 64'sd10000000000;
  endfunction

  // round(atan(2^-i) / (2*pi) * 2^24)
  function automatic logic [ANGLE_W-1:0] atan_lut(input int i);
    logic [ANGLE_W-1:0] a;
    case (i)
      0:  a = 24'd2097152;
      1:  a = 24'd1238021;
      2:  a = 24'd654136;
      3:  a = 24'd332050;
      4:  a = 24'd166669;
      5:  a = 24'd83416;
      6:  a = 24'd41718;
      7:  a = 24'd20860;
      8:  a = 24'd10430;
      9:  a = 24'd5215;
      10: a = 24'd2608;
      11: a = 24'd1304;
      12: a = 24'd652;
      13: a = 24'd326;
      14: a = 24'd163;
      15: a = 24'd81;
      16: a = 24'd41;
      17: a = 24'd20;
      18: a = 24'd10;
      19: a = 24'd5;
      20: a = 24'd3;
      21: a = 24'd1;
      22: a = 24'd1;
      default: a = 24'd0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation: rotates (x, y) by +/-atan(2^-SHIFT)
// towards driving the residual angle z to zero.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int                 IW     = 22,
  parameter int                 SHIFT  = 0,
  parameter logic [ANGLE_W-1:0] ATAN_C = 24'd0
) (
  input  logic                      i_clk,
  input  logic                      i_arst_n,
  input  logic                      i_valid,
  input  logic signed [IW-1:0]      i_x,
  input  logic signed [IW-1:0]      i_y,
  input  logic signed [ANGLE_W-1:0] i_z,
  output logic                      o_valid,
  output logic signed [IW-1:0]      o_x,
  output logic signed [IW-1:0]      o_y,
  output logic signed [ANGLE_W-1:0] o_z
);

  logic signed [IW-1:0] x_sh;
  logic signed [IW-1:0] y_sh;

  assign x_sh = i_x >>> SHIFT;
  assign y_sh = i_y >>> SHIFT;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_valid <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
      o_z     <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_z[ANGLE_W-1]) begin
        o_x <= i_x + y_sh;
        o_y <= i_y - x_sh;
        o_z <= i_z + $signed(ATAN_C);
      end else begin
        o_x <= i_x - y_sh;
        o_y <= i_y + x_sh;
        o_z <= i_z - $signed(ATAN_C);
      end
    end
  end

endmodule

// File: rtl/cordic_sin_cos.sv
// Pipelined rotation-mode CORDIC producing sin/cos of a 24-bit phase, one per clock.
// Build option CORDIC_SIN_COS_ROUND_EN: round half up instead of truncating guard bits.
module cordic_sin_cos
  import cordic_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int STAGES = 16,
  parameter int GUARD  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_valid,
  input  logic [ANGLE_W-1:0]       i_angle,
  output logic signed [DATA_W-1:0] o_cos,
  output logic signed [DATA_W-1:0] o_sin,
  output logic                     o_valid
);

  localparam int IW = DATA_W + GUARD + 2;
  localparam logic signed [IW-1:0] K_INIT  = IW'(k_init(DATA_W, GUARD));
  localparam logic signed [IW-1:0] OUT_MAX = IW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [IW-1:0] OUT_MIN = -OUT_MAX;
`ifdef CORDIC_SIN_COS_ROUND_EN
  localparam logic signed [IW-1:0] RND_HALF = IW'(2 ** (GUARD - 1));
`endif

  logic signed [IW-1:0]      x_p [0:STAGES];
  logic signed [IW-1:0]      y_p [0:STAGES];
  logic signed [ANGLE_W-1:0] z_p [0:STAGES];
  logic                      vld_p [0:STAGES];

  function automatic logic signed [DATA_W-1:0] out_fmt(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] s;
`ifdef CORDIC_SIN_COS_ROUND_EN
    s = (v + RND_HALF) >>> GUARD;
`else
    s = v >>> GUARD;
`endif
    if (s > OUT_MAX)
      return OUT_MAX[DATA_W-1:0];
    else if (s < OUT_MIN)
      return OUT_MIN[DATA_W-1:0];
    else
      return s[DATA_W-1:0];
  endfunction

  // Stage 0: quadrant pre-rotation folds the angle into [-90, +90) degrees
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      vld_p[0] <= 1'b0;
      x_p[0]   <= '0;
      y_p[0]   <= '0;
      z_p[0]   <= '0;
    end else begin
      vld_p[0] <= i_valid;
      case (i_angle[ANGLE_W-1 -: 2])
        2'b01: begin
          x_p[0] <= '0;
          y_p[0] <= K_INIT;
          z_p[0] <= $signed(i_angle - QUARTER);
        end
        2'b10: begin
          x_p[0] <= '0;
          y_p[0] <= -K_INIT;
          z_p[0] <= $signed(i_angle + QUARTER);
        end
        default: begin
          x_p[0] <= K_INIT;
          y_p[0] <= '0;
          z_p[0] <= $signed(i_angle);
        end
      endcase
    end
  end

  // Stages 1..STAGES: micro-rotations
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    cordic_stage #(
      .IW     (IW),
      .SHIFT  (i),
      .ATAN_C (atan_lut(i))
    ) u_stage (
      .i_clk    (i_clk),
      .i_arst_n (i_arst_n),
      .i_valid  (vld_p[i]),
      .i_x      (x_p[i]),
      .i_y      (y_p[i]),
      .i_z      (z_p[i]),
      .o_valid  (vld_p[i+1]),
      .o_x      (x_p[i+1]),
      .o_y      (y_p[i+1]),
      .o_z      (z_p[i+1])
    );
  end

  // Output register: drop guard bits and clamp symmetric
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_valid <= 1'b0;
      o_cos   <= '0;
      o_sin   <= '0;
    end else begin
      o_valid <= vld_p[STAGES];
      o_cos   <= out_fmt(x_p[STAGES]);
      o_sin   <= out_fmt(y_p[STAGES]);
    end
  end

endmodule

// File: tb/tb_cordic_sin_cos.sv
// Self-checking bench for cordic_sin_cos: an ideal trig model plus an 18-deep
// valid delay line predict every output cycle.
module tb_cordic_sin_cos;

  localparam int LAT  = 18;
  localparam int TOL  = 3;
  localparam int HMAX = 4096;

  logic               i_clk;
  logic               i_arst_n;
  logic               i_valid;
  logic [23:0]        i_angle;
  logic signed [15:0] o_cos;
  logic signed [15:0] o_sin;
  logic               o_valid;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  bit hv [0:HMAX-1];
  bit hr [0:HMAX-1];
  bit gv [0:HMAX-1];
  int ha [0:HMAX-1];
  int gc [0:HMAX-1];
  int gs [0:HMAX-1];

  cordic_sin_cos #(.DATA_W(16), .STAGES(16), .GUARD(4)) dut (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_valid  (i_valid),
    .i_angle  (i_angle),
    .o_cos    (o_cos),
    .o_sin    (o_sin),
    .o_valid  (o_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int iround(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else          return -$rtoi(-r + 0.5);
  endfunction

  function automatic int ideal(input int a, input bit want_sin);
    real th;
    th = 6.283185307179586 * a / 16777216.0;
    return iround(32767.0 * (want_sin ? $sin(th) : $cos(th)));
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp, input int tol);
    int d;
    d = obs - exp;
    if (d < 0) d = -d;
    vectors++;
    assert ((d <= tol) === 1'b1) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, obs, exp, tol);
    end
  endtask

  // One clock: record the inputs seen at the edge, then check what the model predicts.
  task automatic tick();
    int m;
    bit ev;
    @(posedge i_clk);
    if (cyc >= HMAX) begin
      $display("FAIL history: cycle budget %0d exceeded", HMAX);
      $fatal(1, "history overflow");
    end
    hv[cyc] = i_valid;
    hr[cyc] = i_arst_n;
    ha[cyc] = int'(i_angle);
    #1;
    m  = cyc - (LAT - 1);
    ev = 1'b0;
    if (m >= 0) begin
      ev = hv[m];
      for (int k = m; k <= cyc; k++)
        if (!hr[k]) ev = 1'b0;
    end
    check_eq("o_valid", int'(o_valid), int'(ev));
    if (ev) begin
      gv[m] = 1'b1;
      gc[m] = o_cos;
      gs[m] = o_sin;
      check_near("cos", o_cos, ideal(ha[m], 1'b0), TOL);
      check_near("sin", o_sin, ideal(ha[m], 1'b1), TOL);
      check_eq("no_min_code", int'(o_cos == -16'sd32768 || o_sin == -16'sd32768), 0);
    end
    cyc++;
  endtask

  initial begin
    int cnt;
    int base;
    int dir [12];
    int bub [7];
    logic [23:0] phase;

    dir = '{24'h400000, 24'h800000, 24'hC00000, 24'h1FFFFF, 24'h200000, 24'h200001,
            24'h3FFFFF, 24'h400000, 24'hBFFFFF, 24'hC00000, 24'hFFFFFF, 24'h000001};
    bub = '{1, 0, 0, 1, 1, 0, 1};
    for (int k = 0; k < HMAX; k++) gv[k] = 1'b0;

    // Reset held with valid asserted upstream
    i_arst_n = 1'b0;
    i_valid  = 1'b1;
    i_angle  = 24'h000000;
    repeat (3) tick();
    check_eq("rst_valid", int'(o_valid), 0);
    check_eq("rst_cos", o_cos, 0);
    check_eq("rst_sin", o_sin, 0);

    // First sample after release: angle 0, count the latency
    i_arst_n = 1'b1;
    i_valid  = 1'b1;
    i_angle  = 24'h000000;
    tick();
    i_valid = 1'b0;
    cnt = 1;
    while (!o_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    check_eq("first_latency", cnt, LAT);
    check_eq("cos0_exact_window", int'(o_cos >= 32764), 1);
    repeat (3) tick();

    // Cardinal, 45 degree neighbourhood and quadrant boundaries
    base = cyc;
    for (int k = 0; k < 12; k++) begin
      i_valid = 1'b1;
      i_angle = dir[k][23:0];
      tick();
    end
    i_valid = 1'b0;
    repeat (LAT + 2) tick();
    check_eq("diag_seen", int'(gv[base+3] & gv[base+4] & gv[base+5]), 1);
    check_near("cos45", gc[base+4], 23170, TOL);
    check_near("sin45", gs[base+4], 23170, TOL);
    check_near("cos45_lo_nb", gc[base+3], gc[base+4], 1);
    check_near("sin45_lo_nb", gs[base+3], gs[base+4], 1);
    check_near("cos45_hi_nb", gc[base+5], gc[base+4], 1);
    check_near("sin45_hi_nb", gs[base+5], gs[base+4], 1);
    check_near("q1_boundary_cos", gc[base+6], gc[base+7], TOL);
    check_near("q3_boundary_sin", gs[base+8], gs[base+9], TOL);

    // Bubble pattern
    for (int k = 0; k < 7; k++) begin
      i_valid = bub[k][0];
      i_angle = 24'($urandom);
      tick();
    end
    i_valid = 1'b0;
    repeat (LAT + 2) tick();

    // Random angles with random bubbles
    for (int k = 0; k < 300; k++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_angle = 24'($urandom);
      tick();
    end

    // Phase-accumulator sweep, continuous enable
    phase = 24'h0;
    for (int k = 0; k < 400; k++) begin
      i_valid = 1'b1;
      i_angle = phase;
      phase   = phase + 24'h00A3D7;
      tick();
    end

    // Reset pulse with a full pipeline
    i_arst_n = 1'b0;
    #1;
    check_eq("midrst_valid", int'(o_valid), 0);
    check_eq("midrst_cos", o_cos, 0);
    check_eq("midrst_sin", o_sin, 0);
    tick();
    i_arst_n = 1'b1;
    i_valid  = 1'b0;
    repeat (LAT + 4) tick();

    // Latency again after the mid-stream reset
    i_valid = 1'b1;
    i_angle = 24'h155555;
    tick();
    i_valid = 1'b0;
    cnt = 1;
    while (!o_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    check_eq("post_rst_latency", cnt, LAT);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
